cla_add_sequencer: RTL and testbench

Two-requester, multi-cycle adder controller built around a 4-bit carry-lookahead slice. It arbitrates round-robin between two requesters and captures the granted WIDTH-bit operands. It then steps the 4-bit slice LSB-nibble first, carrying between nibbles in a register, and returns sum, carry-out and signed overflow over a valid/ready response channel. It sits between operand producers and result consumers wherever a wide add is needed but only nibble-wide carry-lookahead hardware is budgeted.

---
 rtl/cla_add_sequencer.sv | 108 ++++++++++
 tb/tb_cla_add_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cla_add_sequencer.sv
// cla_add_sequencer: round-robin two-requester wide adder stepped through a 4-bit carry-lookahead slice
module cla_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             rsp_id,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q;
    logic [CW-1:0] cnt_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d, rsp_sum_q;
    logic carry_q, prio_q, rsp_cout_q, rsp_ovf_q, rsp_id_q;
    logic grant_id, accept;
    logic [3:0] na, nb, g, p, ns;
    logic [4:0] c;
    // Arbitration: a lone valid wins, a tie goes to the priority pointer
    always_comb begin
        grant_id = (req0_valid && req1_valid) ? prio_q : req1_valid;
        req0_ready = rst_n && state_q == IDLE && !grant_id;
        req1_ready = rst_n && state_q == IDLE && grant_id;
        accept = state_q == IDLE && (grant_id ? req1_valid : req0_valid);
    end
    // 4-bit carry-lookahead slice on the low nibbles, and the sum register shifted in from the top
    always_comb begin
        na = a_q[3:0];
        nb = b_q[3:0];
        g = na & nb;
        p = na ^ nb;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        ns = p ^ c[3:0];
        sum_d = sum_q >> 4;
        sum_d[WIDTH-1 -: 4] = ns;
    end
    // Control FSM: capture operands, step one nibble per cycle, hold the result until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
            carry_q <= 1'b0;
            prio_q <= 1'b0;
            rsp_sum_q <= '0;
            rsp_cout_q <= 1'b0;
            rsp_ovf_q <= 1'b0;
            rsp_id_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    a_q <= grant_id ? req1_a : req0_a;
                    b_q <= grant_id ? req1_b : req0_b;
                    carry_q <= grant_id ? req1_cin : req0_cin;
                    rsp_id_q <= grant_id;
                    prio_q <= ~grant_id;
                    cnt_q <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    a_q <= a_q >> 4;
                    b_q <= b_q >> 4;
                    sum_q <= sum_d;
                    carry_q <= c[4];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        rsp_sum_q <= sum_d;
                        rsp_cout_q <= c[4];
                        rsp_ovf_q <= c[3] ^ c[4];
                        state_q <= DONE;
                    end
                end
                DONE: if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign rsp_valid = state_q == DONE;
    assign busy = state_q != IDLE;
    assign rsp_sum = rsp_sum_q;
    assign rsp_cout = rsp_cout_q;
    assign rsp_ovf = rsp_ovf_q;
    assign rsp_id = rsp_id_q;
endmodule

// File: tb/tb_cla_add_sequencer.sv
// tb_cla_add_sequencer: randomized check of the sequenced adder against an arithmetic reference model
module tb_cla_add_sequencer;
    localparam int W = 16;
    localparam int NIB = W / 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b, rsp_sum;
    logic rsp_valid, rsp_ready, rsp_cout, rsp_ovf, rsp_id, busy;
    int total = 0;
    int bad = 0;
    logic model_prio = 1'b0;
    logic obs_id;

    always #5 clk = ~clk;

    cla_add_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .rsp_ovf(rsp_ovf), .rsp_id(rsp_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set0(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        req0_a = a; req0_b = b; req0_cin = ci; req0_valid = 1'b1;
    endtask

    task automatic set1(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        req1_a = a; req1_b = b; req1_cin = ci; req1_valid = 1'b1;
    endtask

    // Called just after a falling edge with the requests already driven.
    task automatic run_op(input int hold);
        logic w, ec, co, ov;
        logic [W-1:0] ea, eb, s;
        logic [W:0] full;
        int n;
        w = (req0_valid && req1_valid) ? model_prio : req1_valid;
        ea = w ? req1_a : req0_a;
        eb = w ? req1_b : req0_b;
        ec = w ? req1_cin : req0_cin;
        full = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
        s = full[W-1:0];
        co = full[W];
        ov = (ea[W-1] == eb[W-1]) && (s[W-1] != ea[W-1]);
        #1;
        chk("grant_rdy0", req0_ready, !w);
        chk("grant_rdy1", req1_ready, w);
        @(posedge clk);
        #1;
        if (w) req1_valid = 1'b0; else req0_valid = 1'b0;
        model_prio = ~w;
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 20) begin
            chk("run_rdy", {req0_ready, req1_ready}, 0);
            chk("run_busy", busy, 1);
            n++;
            @(negedge clk);
        end
        chk("latency", n, NIB);
        chk("sum", rsp_sum, s);
        chk("cout", rsp_cout, co);
        chk("ovf", rsp_ovf, ov);
        chk("id", rsp_id, w);
        obs_id = rsp_id;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_sum", rsp_sum, s);
            chk("hold_flags", {rsp_cout, rsp_ovf, rsp_id}, {co, ov, w});
            chk("hold_busy", busy, 1);
            chk("hold_rdy", {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_valid", rsp_valid, 0);
        chk("post_busy", busy, 0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", {req0_ready, req1_ready}, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out", {rsp_sum, rsp_cout, rsp_ovf, rsp_id}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        set0(16'h1234, 16'h4321, 1'b0); run_op(0);
        chk("dir_5555", rsp_sum, 16'h5555);
        set1(16'hFFFF, 16'h0001, 1'b0); run_op(0);
        set1(16'h0000, 16'h0000, 1'b1); run_op(5);
        set0(16'h7FFF, 16'h0001, 1'b0); run_op(0);
        set0(16'h8000, 16'h8000, 1'b0); run_op(1);
        // Reset in the second RUN cycle of a requester-0 operation.
        set0(16'hABCD, 16'h1111, 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req1_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", rsp_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_out", {rsp_sum, rsp_cout, rsp_ovf, rsp_id}, 0);
        chk("arst_rdy", {req0_ready, req1_ready}, 0);
        req1_valid = 1'b0;
        model_prio = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("arst_no_rsp", {rsp_valid, busy}, 0);
        end
        // Both requesters valid continuously: strict alternation starting at 0.
        set0($urandom, $urandom, 1'($urandom)); set1($urandom, $urandom, 1'($urandom));
        for (int i = 0; i < 4; i++) begin
            run_op(0);
            chk("rr_seq", obs_id, i % 2);
            if (obs_id) set1($urandom, $urandom, 1'($urandom));
            else set0($urandom, $urandom, 1'($urandom));
        end
        chk("rr_both", {req0_valid, req1_valid}, 2'b11);
        for (int i = 0; i < 40; i++) begin
            if (!req0_valid && $urandom_range(1, 0) == 1) set0($urandom, $urandom, 1'($urandom));
            if (!req1_valid && $urandom_range(1, 0) == 1) set1($urandom, $urandom, 1'($urandom));
            if (!req0_valid && !req1_valid) set0($urandom, $urandom, 1'($urandom));
            run_op(int'($urandom_range(3, 0)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
